shreg_univ: RTL and testbench
=============================

# shreg_univ

Parametrised universal shift register: the next generation of the single-bit `d_ff` storage element. Provides a WIDTH-bit register with hold, shift-right, shift-left and parallel-load modes, serial ports at both ends, and a shift counter that pulses `done` once a full word has been shifted out. It is the common building block for serialisers, deserialisers and delay lines elsewhere in the design.

## Interface
- `WIDTH`, 8, register width in bits; legal range WIDTH >= 2.
- `CW`, derived localparam, width of the shift counter: $clog2(WIDTH+1).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-high.
- `en`  in  1  clock enable; when low, all state holds.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `sin_r`  in  1  serial input entering at MSB on shift right.
- `sin_l`  in  1  serial input entering at LSB on shift left.
- `d`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  register contents.
- `sout_r`  out  1  q[0], the bit leaving on shift right.
- `sout_l`  out  1  q[WIDTH-1], the bit leaving on shift left.
- `cnt`  out  CW  shifts since last load/reset; saturates at WIDTH.
- `done`  out  1  one-cycle pulse when `cnt` reaches WIDTH.
- `rot`  in  1  rotate select; present only with SHREG_ROTATE_EN.

## Operation
- Reset (rst=1 at an edge; overrides `en` and `mode`): q=0, cnt=0, done=0.
- en=0: q and cnt hold; done=0 on the next edge.
- en=1, mode 00: q and cnt hold; done=0.
- en=1, mode 01: q <= {sin_r, q[WIDTH-1:1]}; cnt increments if below WIDTH.
- en=1, mode 10: q <= {q[WIDTH-2:0], sin_l}; cnt increments if below WIDTH.
- en=1, mode 11: q <= d; cnt <= 0; done=0.
- Shift direction may change between cycles; both directions count toward the same `cnt`.
- done=1 for exactly the cycle after the edge where cnt goes WIDTH-1 -> WIDTH. Further shifts with cnt=WIDTH keep cnt=WIDTH, done=0.
- A load in the cycle that would have reached WIDTH wins: cnt=0, no done.

## Timing
- All outputs are registered; every change is visible one clock after the controlling edge.
- `sout_r`/`sout_l` are combinational slices of `q` and carry no additional latency.
- Reset takes effect on the first rising edge with rst=1; rst asserted mid-shift discards contents and count.

## Configuration
- `SHREG_ROTATE_EN` defined: `rot` port exists. When rot=1 in a shift mode, the fill bit is the outgoing bit (q[0] into MSB on right, q[WIDTH-1] into LSB on left) and sin_r/sin_l are ignored. Counting and `done` are unchanged.
- Not defined: no `rot` port. Shifts always fill from sin_r/sin_l.

## Structure
- `shreg_pkg`: mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
- One sub-module, `shreg_bit_cnt`: a saturating CW-bit counter with clear, increment and terminal pulse. It drives `cnt` and `done`.

## Test plan
- Reset: rst=1 for 2 cycles with en=1, mode=11, d=8'hFF -> q=8'h00, cnt=0, done=0.
- Load 8'hA5, then shift right 8 cycles with sin_r=0 -> q steps 52,29,14,0A,05,02,01,00. The sout_r sequence sampled before each shift is 1,0,1,0,0,1,0,1. done pulses once after the 8th shift. A 9th shift keeps cnt=8 and done=0.
- Load 8'h81, then shift left 3 cycles with sin_l=1 -> q = 03, 07, 0F; cnt=3.
- Load 8'h3C, shift right 2, hold en=0 for 3 cycles, shift right 6 -> q is frozen at 0F while en=0. done pulses only after the 8th total shift.
- Shift 7 times, then load 8'h55 on the next cycle -> cnt=0, no done pulse, q=55.
- With SHREG_ROTATE_EN: load 8'h81, rot=1, shift right -> q=C0. Without the macro, the same sequence with sin_r=0 -> q=40.

Source files
------------

// File: rtl/shreg_pkg.sv
// shreg_pkg
// Shared definitions for the universal shift register: the two-bit mode
// encodings used on the shreg_univ `mode` port.
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shreg_mode_e;

endpackage

// File: rtl/shreg_bit_cnt.sv
// shreg_bit_cnt
// Saturating shift counter with clear, increment and a one-cycle terminal
// pulse. The pulse fires only on the increment that takes the count from
// MAX-1 to MAX; increments at MAX are ignored.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (count and pulse to zero)
//   clr   clear count to zero (takes priority over inc)
//   inc   increment request
//   cnt   current count, saturates at MAX
//   done  one-cycle pulse after the edge where cnt reached MAX
module shreg_bit_cnt #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX);
  localparam logic [CW-1:0] CNT_PRE = CW'(MAX - 1);

  // done is cleared on every edge unless this edge performs the final
  // increment, which makes it a pulse that no later edge can re-fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
        cnt  <= cnt + CW'(1);
        done <= (cnt == CNT_PRE);
      end
    end
  end

endmodule

// File: rtl/shreg_univ.sv
// shreg_univ
// Parametrised universal shift register with hold, shift-right, shift-left
// and parallel-load modes, serial ports at both ends and a saturating shift
// counter that pulses `done` when a full word has been shifted.
//
// Optional feature: define SHREG_ROTATE_EN to add the `rot` input. With
// rot=1 in a shift mode the outgoing bit is recirculated into the vacated
// end instead of sin_r/sin_l.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, overrides en and mode
//   en      clock enable; low holds all state
//   mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r   serial input entering at MSB on shift right
//   sin_l   serial input entering at LSB on shift left
//   d       parallel load data
//   q       register contents
//   sout_r  q[0]
//   sout_l  q[WIDTH-1]
//   cnt     shifts since last load/reset, saturates at WIDTH
//   done    one-cycle pulse when cnt reaches WIDTH
//   rot     rotate select (SHREG_ROTATE_EN only)
module shreg_univ
  import shreg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  logic fill_r;
  logic fill_l;
  logic do_shift;
  logic do_load;

  // Bits entering the vacated end on each shift direction.
  always_comb begin
    fill_r = sin_r;
    fill_l = sin_l;
`ifdef SHREG_ROTATE_EN
    if (rot) begin
      fill_r = q[0];
      fill_l = q[WIDTH-1];
    end
`endif
  end

  assign do_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
  assign do_load  = en && (mode == MODE_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      case (mode)
        MODE_SHR:  q <= {fill_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], fill_l};
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  // Both shift directions feed the same counter; a load clears it and
  // therefore also suppresses a pulse that this edge would have produced.
  shreg_bit_cnt #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (do_load),
    .inc  (do_shift),
    .cnt  (cnt),
    .done (done)
  );

endmodule

// File: tb/tb_shreg_univ.sv
// tb_shreg_univ
// Self-checking bench for shreg_univ (WIDTH=8): a table of directed vectors
// with hand-computed results, plus hand-written sequences for the done
// pulse and the rotate/fill behaviour.
module tb_shreg_univ;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] d;
`ifdef SHREG_ROTATE_EN
  logic       rot;
`endif
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [3:0] cnt;
  logic       done;

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  shreg_univ #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .d      (d),
`ifdef SHREG_ROTATE_EN
    .rot    (rot),
`endif
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [7:0] dd,
                        input logic [7:0] eq, input logic [3:0] ec,
                        input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl; v.d = dd;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic sr, input logic sl, input logic [7:0] dd);
    @(negedge clk);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic checkRow(input int idx, input logic [7:0] eq,
                          input logic [3:0] ec, input logic ed);
    checkOutput("q",      idx, 32'(q),      32'(eq));
    checkOutput("cnt",    idx, 32'(cnt),    32'(ec));
    checkOutput("done",   idx, 32'(done),   32'(ed));
    checkOutput("sout_r", idx, 32'(sout_r), 32'(eq[0]));
    checkOutput("sout_l", idx, 32'(sout_l), 32'(eq[7]));
  endtask

  initial begin
    int pulses;
    int first_pulse;
    logic [7:0] rot_exp_r;
    logic [7:0] rot_exp_l;

    rst = 1'b1; en = 1'b1; mode = 2'b11; sin_r = 1'b0; sin_l = 1'b0; d = 8'hFF;
`ifdef SHREG_ROTATE_EN
    rot = 1'b0;
`endif

    //      rst en mode sr sl d       q      cnt done
    // Reset overrides a load of FF.
    addVec(1, 1, 2'b11, 0, 0, 8'hFF, 8'h00, 0, 0);
    addVec(1, 1, 2'b11, 0, 0, 8'hFF, 8'h00, 0, 0);
    // Load A5, shift right 8 times with sin_r=0, then a 9th and a hold.
    addVec(0, 1, 2'b11, 0, 0, 8'hA5, 8'hA5, 0, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h52, 1, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h29, 2, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h14, 3, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h0A, 4, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h05, 5, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h02, 6, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h01, 7, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h00, 8, 1);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h00, 8, 0);
    addVec(0, 1, 2'b00, 1, 1, 8'hFF, 8'h00, 8, 0);
    // Load 81, shift left 3 with sin_l=1.
    addVec(0, 1, 2'b11, 0, 0, 8'h81, 8'h81, 0, 0);
    addVec(0, 1, 2'b10, 0, 1, 8'h00, 8'h03, 1, 0);
    addVec(0, 1, 2'b10, 0, 1, 8'h00, 8'h07, 2, 0);
    addVec(0, 1, 2'b10, 0, 1, 8'h00, 8'h0F, 3, 0);
    // Load 3C, shift right 2, freeze 3 cycles, shift right 6 with sin_r=1.
    addVec(0, 1, 2'b11, 0, 0, 8'h3C, 8'h3C, 0, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h1E, 1, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h0F, 2, 0);
    addVec(0, 0, 2'b01, 1, 1, 8'hFF, 8'h0F, 2, 0);
    addVec(0, 0, 2'b11, 1, 1, 8'hFF, 8'h0F, 2, 0);
    addVec(0, 0, 2'b10, 1, 1, 8'hFF, 8'h0F, 2, 0);
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'h87, 3, 0);
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'hC3, 4, 0);
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'hE1, 5, 0);
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'hF0, 6, 0);
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'hF8, 7, 0);
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'hFC, 8, 1);
    // en=0 right after the pulse: state holds, done drops.
    addVec(0, 0, 2'b01, 1, 0, 8'h00, 8'hFC, 8, 0);
    // Mixed directions for 7 shifts, then a load wins over the count.
    addVec(0, 1, 2'b11, 0, 0, 8'h00, 8'h00, 0, 0);
    addVec(0, 1, 2'b10, 0, 1, 8'h00, 8'h01, 1, 0);
    addVec(0, 1, 2'b10, 0, 1, 8'h00, 8'h03, 2, 0);
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'h81, 3, 0);
    addVec(0, 1, 2'b10, 0, 0, 8'h00, 8'h02, 4, 0);
    addVec(0, 1, 2'b01, 0, 0, 8'h00, 8'h01, 5, 0);
    addVec(0, 1, 2'b10, 0, 1, 8'h00, 8'h03, 6, 0);
    addVec(0, 1, 2'b10, 0, 1, 8'h00, 8'h07, 7, 0);
    addVec(0, 1, 2'b11, 0, 0, 8'h55, 8'h55, 0, 0);
    addVec(0, 1, 2'b00, 0, 0, 8'h00, 8'h55, 0, 0);
    // Reset mid-shift discards contents and count, even with en=0.
    addVec(0, 1, 2'b01, 1, 0, 8'h00, 8'hAA, 1, 0);
    addVec(1, 0, 2'b01, 1, 0, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode,
                    vecs[i].sin_r, vecs[i].sin_l, vecs[i].d);
      checkRow(i, vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_done);
    end

    // done must pulse exactly once, after the 8th of 20 consecutive shifts.
    applyStimulus(0, 1, 2'b11, 0, 0, 8'h5A);
    pulses = 0;
    first_pulse = -1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(0, 1, (k % 2 == 0) ? 2'b10 : 2'b01, 1, 0, 8'h00);
      if (done === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
    checkOutput("pulse_count", 100, 32'(pulses), 32'd1);
    checkOutput("pulse_index", 101, 32'(first_pulse), 32'd8);
    checkOutput("cnt_sat",     102, 32'(cnt), 32'd8);

    // Fill behaviour: rotate recirculates the outgoing bit, otherwise the
    // serial inputs (held at 0 here) fill the vacated end.
`ifdef SHREG_ROTATE_EN
    rot = 1'b1;
    rot_exp_r = 8'hC0;
    rot_exp_l = 8'h81;
`else
    rot_exp_r = 8'h40;
    rot_exp_l = 8'h80;
`endif
    applyStimulus(0, 1, 2'b11, 0, 0, 8'h81);
    applyStimulus(0, 1, 2'b01, 0, 0, 8'h00);
    checkOutput("fill_right", 103, 32'(q), 32'(rot_exp_r));
    checkOutput("fill_cnt",   104, 32'(cnt), 32'd1);
    applyStimulus(0, 1, 2'b10, 0, 0, 8'h00);
    checkOutput("fill_left",  105, 32'(q), 32'(rot_exp_l));
`ifdef SHREG_ROTATE_EN
    rot = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
